// File: rtl/seg7_scan_ctrl_if.sv
// Load-side bus of the seven-segment scan controller.
// The upstream datapath (master) presents a 16-bit hex value plus four
// decimal-point enables and pulses load_i; the controller (slave) reports
// pending_o while the captured value waits for the next frame boundary.
interface seg7_scan_ctrl_if;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic        pending_o;

    modport master (
        output data_i,
        output dp_i,
        output load_i,
        input  pending_o
    );

    modport slave (
        input  data_i,
        input  dp_i,
        input  load_i,
        output pending_o
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment display driver.
// A prescaler sets the slot length, a 2-bit counter scans the digits, and a
// shadow/display register pair makes new values take effect only at a frame
// boundary so a frame is never torn. All display outputs are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero nibble (digit 0 is always shown).
module seg7_scan_ctrl #(
    parameter int unsigned CLK_DIV        = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_ctrl_if.slave   bus,
    output logic [1:0]        digit_o,
    output logic [3:0]        an_o,
    output logic [6:0]        seg_o,
    output logic              dp_o
);

    localparam int unsigned    CntW   = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [3:0]      shadow_dp_q, shadow_dp_d;
    logic [15:0]     disp_q, disp_d;
    logic [3:0]      disp_dp_q, disp_dp_d;
    logic            pending_q, pending_d;
    logic [1:0]      digit_out_q;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            tick;
    logic            boundary;

    // Prescaler, scan counter and shadow/display buffering.
    always_comb begin
        tick        = (div_cnt_q == CntMax);
        boundary    = tick && (digit_q == 2'd3);
        div_cnt_d   = tick ? '0 : div_cnt_q + CntW'(1);
        digit_d     = tick ? digit_q + 2'd1 : digit_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pending_d   = pending_q;
        // The display takes the shadow as it was before any same-cycle load.
        if (boundary && pending_q) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            pending_d = 1'b0;
        end
        // A load always wins over the pending clear; it waits for the next boundary.
        if (bus.load_i) begin
            shadow_d    = bus.data_i;
            shadow_dp_d = bus.dp_i;
            pending_d   = 1'b1;
        end
    end

    // Next values of the registered display outputs for the current digit.
    always_comb begin
        logic [3:0] an_act;
        logic [6:0] seg_act;
        logic       dp_act;
`ifdef LEADING_ZERO_BLANK_EN
        logic [1:0] lead;
`endif
        an_act  = 4'b0001 << digit_q;
        seg_act = hex7(disp_q[{digit_q, 2'b00} +: 4]);
        dp_act  = disp_dp_q[digit_q];
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_q[15:12] != 4'h0) begin
            lead = 2'd3;
        end else if (disp_q[11:8] != 4'h0) begin
            lead = 2'd2;
        end else if (disp_q[7:4] != 4'h0) begin
            lead = 2'd1;
        end else begin
            lead = 2'd0;
        end
        if (digit_q > lead) begin
            an_act  = 4'b0000;
            seg_act = 7'b0000000;
            dp_act  = 1'b0;
        end
`endif
        an_d  = an_act ^ {4{SEG_ACTIVE_LOW}};
        seg_d = seg_act ^ {7{SEG_ACTIVE_LOW}};
        dp_d  = dp_act ^ SEG_ACTIVE_LOW;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            digit_q     <= 2'd0;
            shadow_q    <= 16'h0000;
            shadow_dp_q <= 4'h0;
            disp_q      <= 16'h0000;
            disp_dp_q   <= 4'h0;
            pending_q   <= 1'b0;
            digit_out_q <= 2'd0;
            an_q        <= {4{SEG_ACTIVE_LOW}};
            seg_q       <= {7{SEG_ACTIVE_LOW}};
            dp_q        <= SEG_ACTIVE_LOW;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_q     <= digit_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pending_q   <= pending_d;
            digit_out_q <= digit_q;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.pending_o = pending_q;
    assign digit_o       = digit_out_q;
    assign an_o          = an_q;
    assign seg_o         = seg_q;
    assign dp_o          = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (CLK_DIV=4, active-low outputs).
// A cycle-level reference model derives the scan position from the number of
// clocks since reset and checks every output on every cycle; directed
// sequences and a hex-decode vector table cover the corner cases.
module tb_seg7_scan_ctrl;

    localparam int unsigned Div   = 4;
    localparam int unsigned Frame = 4 * Div;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] digit_o;
    logic [3:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;

    seg7_scan_ctrl_if bus_if ();

    seg7_scan_ctrl #(
        .CLK_DIV        (Div),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .digit_o (digit_o),
        .an_o    (an_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } hex_vec_t;

    hex_vec_t vecs [16];

    // Reference model state.
    int          m_n;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_sdp, m_ddp;
    bit          m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [1:0]  e_digit;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] lut [16];
        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return lut[nib];
    endfunction

    function automatic logic [6:0] seg_al(input logic [6:0] v);
        return ~v;
    endfunction

    function automatic logic [3:0] an_al(input int d);
        logic [3:0] one;
        one = 4'b0001 << d;
        return ~one;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model: outputs come from the state before the edge.
    task automatic model_edge();
        int d;
        bit bnd;
`ifdef LEADING_ZERO_BLANK_EN
        int lead;
`endif
        if (rst) begin
            m_n = 0; m_shadow = '0; m_sdp = '0; m_pend = 0; m_disp = '0; m_ddp = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_digit = 2'd0;
        end else begin
            d       = (m_n / Div) % 4;
            bnd     = (m_n % Frame) == Frame - 1;
            e_digit = 2'(d);
            e_an    = an_al(d);
            e_seg   = seg_al(hex7(4'((m_disp >> (4 * d)) & 16'hF)));
            e_dp    = ~m_ddp[d];
`ifdef LEADING_ZERO_BLANK_EN
            lead = 0;
            for (int k = 0; k < 4; k++) begin
                if (((m_disp >> (4 * k)) & 16'hF) != 0) lead = k;
            end
            if (d > lead) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
`endif
            if (bnd && m_pend) begin
                m_disp = m_shadow;
                m_ddp  = m_sdp;
            end
            if (bus_if.load_i) begin
                m_shadow = bus_if.data_i;
                m_sdp    = bus_if.dp_i;
                m_pend   = 1;
            end else if (bnd) begin
                m_pend = 0;
            end
            m_n++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("an", an_o, e_an);
        check("seg", seg_o, e_seg);
        check("dp", dp_o, e_dp);
        check("digit", digit_o, e_digit);
        check("pending", bus_if.pending_o, m_pend);
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] dp);
        bus_if.data_i = data;
        bus_if.dp_i   = dp;
        bus_if.load_i = 1'b1;
        step();
        bus_if.load_i = 1'b0;
    endtask

    task automatic wait_xfer(input string name);
        for (int k = 0; k < 3 * Frame && m_pend; k++) step();
        check(name, bus_if.pending_o, 0);
    endtask

    initial begin
        vecs[0]  = '{4'h0, 7'h3F}; vecs[1]  = '{4'h1, 7'h06};
        vecs[2]  = '{4'h2, 7'h5B}; vecs[3]  = '{4'h3, 7'h4F};
        vecs[4]  = '{4'h4, 7'h66}; vecs[5]  = '{4'h5, 7'h6D};
        vecs[6]  = '{4'h6, 7'h7D}; vecs[7]  = '{4'h7, 7'h07};
        vecs[8]  = '{4'h8, 7'h7F}; vecs[9]  = '{4'h9, 7'h6F};
        vecs[10] = '{4'hA, 7'h77}; vecs[11] = '{4'hB, 7'h7C};
        vecs[12] = '{4'hC, 7'h39}; vecs[13] = '{4'hD, 7'h5E};
        vecs[14] = '{4'hE, 7'h79}; vecs[15] = '{4'hF, 7'h71};

        rst = 1'b1;
        bus_if.data_i = '0;
        bus_if.dp_i   = '0;
        bus_if.load_i = 1'b0;

        // Reset held for three cycles.
        repeat (3) begin
            step();
            check("rst_an", an_o, 4'hF);
            check("rst_seg", seg_o, 7'h7F);
            check("rst_dp", dp_o, 1);
            check("rst_pending", bus_if.pending_o, 0);
        end
        rst = 1'b0;
        step();
        check("first_an", an_o, 4'b1110);
        check("first_seg", seg_o, 7'b1000000);

        // Free run: each digit held Div cycles, wrapping after digit 3.
        for (int i = 1; i < 2 * Frame; i++) begin
            step();
            check("scan_an", an_o, an_al((i / Div) % 4));
            check("scan_digit", digit_o, (i / Div) % 4);
        end

        // Mid-frame load of 12AF with dp on digit 0.
        repeat (5) step();
        load(16'h12AF, 4'b0001);
        check("mid_pending", bus_if.pending_o, 1);
        wait_xfer("mid_xfer");
        step();
        check("mid_d0_seg", seg_o, 7'b0001110);
        check("mid_d0_dp", dp_o, 0);
        check("mid_d0_an", an_o, 4'b1110);
        repeat (12) step();
        check("mid_d3_seg", seg_o, 7'b1111001);
        check("mid_d3_an", an_o, 4'b0111);

        // Load on the boundary cycle, then overwrite before the next boundary.
        for (int k = 0; k < Frame && (m_n % Frame) != Frame - 1; k++) step();
        load(16'h1111, 4'b0000);
        check("bnd_pending", bus_if.pending_o, 1);
        repeat (5) step();
        load(16'h2222, 4'b0000);
        for (int i = 0; i < 2 * Frame; i++) begin
            step();
            if (digit_o == 2'd0) check("never_1111", seg_o == seg_al(7'h06), 0);
        end
        check("ovw_pending", bus_if.pending_o, 0);
        for (int k = 0; k < Frame && digit_o != 2'd0; k++) step();
        check("ovw_d0_seg", seg_o, seg_al(7'h5B));

        // Reset while a load is pending discards it.
        for (int k = 0; k < Frame && (m_n % Frame) != 2; k++) step();
        load(16'h5555, 4'b1111);
        repeat (3) step();
        check("rst5_pend_before", bus_if.pending_o, 1);
        rst = 1'b1;
        step();
        check("rst5_pending", bus_if.pending_o, 0);
        check("rst5_an", an_o, 4'hF);
        step();
        rst = 1'b0;
        for (int i = 0; i < 2 * Frame; i++) begin
            step();
            check("no_5555", seg_o == seg_al(7'h6D), 0);
`ifdef LEADING_ZERO_BLANK_EN
            check("zero_seg", seg_o, digit_o == 2'd0 ? seg_al(7'h3F) : 7'h7F);
`else
            check("zero_seg", seg_o, seg_al(7'h3F));
`endif
        end

        // Leading-zero behaviour for 0042 and 0000.
        load(16'h0042, 4'b0000);
        wait_xfer("lz42_xfer");
        for (int i = 0; i < Frame; i++) begin
            step();
`ifdef LEADING_ZERO_BLANK_EN
            check("lz42_an", an_o, digit_o >= 2'd2 ? 4'hF : an_al(digit_o));
`else
            check("lz42_an", an_o, an_al(digit_o));
`endif
            if (digit_o == 2'd0) check("lz42_d0", seg_o, seg_al(7'h5B));
            if (digit_o == 2'd1) check("lz42_d1", seg_o, seg_al(7'h66));
        end
        load(16'h0000, 4'b0000);
        wait_xfer("lz0_xfer");
        for (int i = 0; i < Frame; i++) begin
            step();
`ifdef LEADING_ZERO_BLANK_EN
            check("lz0_an", an_o, digit_o == 2'd0 ? an_al(0) : 4'hF);
`else
            check("lz0_an", an_o, an_al(digit_o));
`endif
        end

        // Hex decode table, shown on digit 0 of each new frame.
        for (int v = 0; v < 16; v++) begin
            load({4{vecs[v].nib}}, 4'($urandom_range(0, 15)));
            wait_xfer("hex_xfer");
            step();
            check("hex_seg", seg_o, seg_al(vecs[v].seg));
        end

        // Random loads and occasional resets against the reference model.
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus_if.load_i = ($urandom_range(0, 7) == 0);
            bus_if.data_i = 16'($urandom);
            bus_if.dp_i   = 4'($urandom_range(0, 15));
            step();
        end
        rst           = 1'b0;
        bus_if.load_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
